spi_xfer_sequencer: RTL and testbench
=====================================

# spi_xfer_sequencer

Wishbone master that drives the `simple_spi_top` register interface to run byte-level SPI transfers on behalf of a simple valid/ready command stream.
- On reset release it programs SPCR/SPER. Per command byte it writes SPDR, polls SPSR until the read FIFO is non-empty, reads SPDR and returns the received byte.
- Owns slave-select with burst framing and recovers from stalled transfers by timeout.
- Sits between a command source (I2C bridge side or local controller) and the SPI core, replacing direct Wishbone pass-through.

## Interface
Parameters:
- `SPR`, 2'b00: SPCR clock-rate bits [1:0].
- `ESPR`, 2'b00: SPER extended rate bits [1:0].
- `CPOL`, 1'b0: SPCR bit 3.
- `CPHA`, 1'b0: SPCR bit 2.
- `POLL_LIMIT`, 255: max SPSR reads per byte before timeout (1..255).

Ports:
- `clk_i` in 1: clock; all logic on rising edge.
- `rst_i` in 1: reset; asynchronous, active-low.
- `cmd_valid_i` in 1: command byte valid.
- `cmd_ready_o` out 1: sequencer accepts command.
- `cmd_data_i` in 8: byte to transmit.
- `cmd_last_i` in 1: deassert slave-select after this byte.
- `rsp_valid_o` out 1: response valid.
- `rsp_ready_i` in 1: response consumed.
- `rsp_data_o` out 8: received byte (0x00 on error).
- `rsp_err_o` out 1: timeout flag for this response.
- `ss_n_o` out 1: slave select, active low.
- `busy_o` out 1: high in any state except IDLE.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o` out 1 each: Wishbone master controls.
- `wb_adr_o` out 8: register address.
- `wb_dat_o` out 8: write data.
- `wb_dat_i` in 8: read data.
- `wb_ack_i` in 1: bus termination.

## Operation
- Register map (adr): 0x00 SPCR, 0x01 SPSR, 0x02 SPDR, 0x03 SPER. SPSR bit0 = RFEMPTY.
- SPCR value CFG = {1'b0, 1'b1 (SPE), 1'b0, 1'b1 (MSTR), CPOL, CPHA, SPR}. Default CFG = 0x50.
- States:
  - CFG_SPCR: write CFG → CFG_SPER.
  - CFG_SPER: write {6'b0, ESPR} → IDLE.
  - IDLE: `cmd_ready_o`=1. On accept, latch data/last, `ss_n_o`←0 → WR_DR.
  - WR_DR: write SPDR → POLL.
  - POLL: read SPSR. If RFEMPTY=0 → RD_DR. Else increment poll count; when count reaches POLL_LIMIT → ERR, otherwise repeat POLL.
  - RD_DR: read SPDR, latch data → RESP.
  - RESP: hold `rsp_valid_o` until `rsp_ready_i`. Then `ss_n_o`←1 if last, → IDLE.
  - ERR: write SPCR=0x00 (disable, flushes FIFOs). Then present response err=1, data 0x00, `ss_n_o`←1, → CFG_SPCR after handshake.
- Poll counter clears on entry to WR_DR.
- Only one command is outstanding at a time. `cmd_ready_o` is 0 outside IDLE.
- Non-last bytes keep `ss_n_o` low across bursts.

## Timing
- Reset values:
  - `cmd_ready_o`=0, `rsp_valid_o`=0, `rsp_data_o`=0x00, `rsp_err_o`=0.
  - `ss_n_o`=1, `busy_o`=1.
  - All wb_* = 0.
  - State CFG_SPCR.
- Reset asserted mid-transfer forces these values immediately, dropping `wb_cyc_o` without waiting for ack. Reconfiguration restarts after release.
- Wishbone access rules:
  - `cyc`/`stb`/`we`/`adr`/`dat_o` are registered and held stable until the cycle `wb_ack_i`=1.
  - They deassert the following cycle; at least one idle cycle between accesses.
  - An access with a 1-cycle ack slave takes 2 cycles (3 cycles including the idle cycle).
- Minimum latency:
  - Accept → `rsp_valid_o`: WR_DR 3 + POLL 3·n + RD_DR 3 + 1 cycles (n ≥ 1 SPSR reads).
  - Reset release → first `cmd_ready_o`: 6 cycles with a 1-cycle ack.
- Boundary cases:
  - A `cmd_valid_i` arriving during RESP waits; it is not accepted in the handshake cycle.
  - If the ack and poll-count-limit events coincide on the same read with RFEMPTY=0, success wins.
  - `rsp_ready_i` held low stalls indefinitely with no Wishbone activity.

## Structure
- Shared include `spi_seq_defs.vh`:
  - Register address localparams.
  - SPCR/SPSR bit positions.
  - State encodings.
- One sub-module `spi_wb_access`: single-access Wishbone master.
  - Start pulse, adr/we/wdata in.
  - Done pulse plus rdata out.
  - Implements the hold-until-ack and idle-cycle rules.
- The top module contains the FSM, poll counter, response and ss_n registers.

## Test plan
- Reset config: release `rst_i` with a 1-cycle-ack SPI model → writes SPCR=0x50, then SPER=0x00; `cmd_ready_o`=1 at cycle 6, `ss_n_o`=1.
- Single byte, miso looped to mosi: cmd 0xA5 with last=1 → `rsp_data_o`=0xA5, err=0. `ss_n_o` is low from accept and high after the response handshake.
- Burst: 0x11, 0x22, 0x33 with last on the third → three responses matching the sent bytes; `ss_n_o` stays low continuously until after the third handshake.
- Timeout: SPI model returns SPSR=0x05 forever with POLL_LIMIT=4 → exactly 4 SPSR reads, then SPCR=0x00 write, response err=1 and data 0x00, then SPCR=0x50 and SPER rewrites.
- Backpressure: hold `rsp_ready_i`=0 for 20 cycles → `rsp_valid_o` and data stay stable, no `wb_cyc_o`, `cmd_ready_o`=0.
- Reset mid-POLL: assert `rst_i`=0 while `wb_cyc_o`=1 → all outputs take reset values in the same cycle; reconfiguration sequence repeats after release.

Source files
------------

// File: rtl/spi_xfer_sequencer_pkg.sv
// ============================================================================
// Module   : spi_xfer_sequencer_pkg
// Contents : Register map, bit positions and FSM encoding for the sequencer
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_xfer_sequencer_pkg;

    localparam logic [7:0] c_adr_spcr = 8'h00;
    localparam logic [7:0] c_adr_spsr = 8'h01;
    localparam logic [7:0] c_adr_spdr = 8'h02;
    localparam logic [7:0] c_adr_sper = 8'h03;

    localparam int c_spcr_spe_bit     = 6;
    localparam int c_spcr_mstr_bit    = 4;
    localparam int c_spsr_rfempty_bit = 0;

    typedef enum logic [3:0] {
        ST_CFG_SPCR = 4'd0,
        ST_CFG_SPER = 4'd1,
        ST_IDLE     = 4'd2,
        ST_WR_DR    = 4'd3,
        ST_POLL     = 4'd4,
        ST_RD_DR    = 4'd5,
        ST_RESP     = 4'd6,
        ST_ERR      = 4'd7,
        ST_ERR_RESP = 4'd8
    } seq_state_t;

    // SPE and MSTR are always set; the rest comes from the rate/mode parameters.
    function automatic logic [7:0] spcr_cfg(input logic cpol, input logic cpha,
                                            input logic [1:0] spr);
        return {1'b0, 1'b1, 1'b0, 1'b1, cpol, cpha, spr};
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_xfer_sequencer_wb_access.sv
// ============================================================================
// Module   : spi_wb_access
// Contents : Single-access Wishbone master; holds the request until ack and
//            leaves the bus idle for at least one cycle afterwards.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_wb_access (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic       i_we,
    input  logic [7:0] i_adr,
    input  logic [7:0] i_wdata,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_rdata,
    output logic       o_wb_cyc,
    output logic       o_wb_stb,
    output logic       o_wb_we,
    output logic [7:0] o_wb_adr,
    output logic [7:0] o_wb_dat,
    input  logic [7:0] i_wb_dat,
    input  logic       i_wb_ack
);

    logic       r_cyc;
    logic       r_we;
    logic [7:0] r_adr;
    logic [7:0] r_dat;
    logic       r_done;
    logic [7:0] r_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_adr   <= 8'h00;
            r_dat   <= 8'h00;
            r_done  <= 1'b0;
            r_rdata <= 8'h00;
        end else begin
            r_done <= 1'b0;
            if (r_cyc) begin
                if (i_wb_ack) begin
                    r_cyc   <= 1'b0;
                    r_we    <= 1'b0;
                    r_adr   <= 8'h00;
                    r_dat   <= 8'h00;
                    r_rdata <= i_wb_dat;
                    r_done  <= 1'b1;
                end
            end else if (i_start && !r_done) begin
                // The done cycle doubles as the mandatory idle cycle.
                r_cyc <= 1'b1;
                r_we  <= i_we;
                r_adr <= i_adr;
                r_dat <= i_we ? i_wdata : 8'h00;
            end
        end
    end

    assign o_busy   = r_cyc;
    assign o_done   = r_done;
    assign o_rdata  = r_rdata;
    assign o_wb_cyc = r_cyc;
    assign o_wb_stb = r_cyc;
    assign o_wb_we  = r_we;
    assign o_wb_adr = r_adr;
    assign o_wb_dat = r_dat;

endmodule

`default_nettype wire

// File: rtl/spi_xfer_sequencer.sv
// ============================================================================
// Module   : spi_xfer_sequencer
// Contents : Runs byte transfers on simple_spi_top over Wishbone for a
//            valid/ready command stream, with slave-select framing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_xfer_sequencer
    import spi_xfer_sequencer_pkg::*;
#(
    parameter logic [1:0] SPR        = 2'b00,
    parameter logic [1:0] ESPR       = 2'b00,
    parameter logic       CPOL       = 1'b0,
    parameter logic       CPHA       = 1'b0,
    parameter int         POLL_LIMIT = 255
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [7:0] cmd_data_i,
    input  logic       cmd_last_i,
    output logic       rsp_valid_o,
    input  logic       rsp_ready_i,
    output logic [7:0] rsp_data_o,
    output logic       rsp_err_o,
    output logic       ss_n_o,
    output logic       busy_o,
    output logic       wb_cyc_o,
    output logic       wb_stb_o,
    output logic       wb_we_o,
    output logic [7:0] wb_adr_o,
    output logic [7:0] wb_dat_o,
    input  logic [7:0] wb_dat_i,
    input  logic       wb_ack_i
);

    localparam logic [7:0] c_cfg        = spcr_cfg(CPOL, CPHA, SPR);
    localparam logic [7:0] c_poll_limit = 8'(POLL_LIMIT);

    seq_state_t r_state, w_next;
    logic [7:0] r_data;
    logic       r_last;
    logic [7:0] r_poll_cnt;
    logic [7:0] r_rsp_data;
    logic       r_ss_n;

    logic       w_access;
    logic       w_we;
    logic [7:0] w_adr;
    logic [7:0] w_wdata;
    logic       w_start;
    logic       w_wb_busy;
    logic       w_done;
    logic [7:0] w_rdata;
    logic [7:0] w_poll_inc;

    assign w_poll_inc = r_poll_cnt + 8'd1;
    assign w_start    = w_access && !w_wb_busy && !w_done;

    always_comb begin
        w_next   = r_state;
        w_access = 1'b0;
        w_we     = 1'b0;
        w_adr    = c_adr_spcr;
        w_wdata  = 8'h00;
        unique case (r_state)
            ST_CFG_SPCR: begin
                w_access = 1'b1;
                w_we     = 1'b1;
                w_wdata  = c_cfg;
                if (w_done) w_next = ST_CFG_SPER;
            end
            ST_CFG_SPER: begin
                w_access = 1'b1;
                w_we     = 1'b1;
                w_adr    = c_adr_sper;
                w_wdata  = {6'b0, ESPR};
                if (w_done) w_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (cmd_valid_i) w_next = ST_WR_DR;
            end
            ST_WR_DR: begin
                w_access = 1'b1;
                w_we     = 1'b1;
                w_adr    = c_adr_spdr;
                w_wdata  = r_data;
                if (w_done) w_next = ST_POLL;
            end
            ST_POLL: begin
                w_access = 1'b1;
                w_adr    = c_adr_spsr;
                // A non-empty FIFO takes priority over the poll limit.
                if (w_done) begin
                    if (!w_rdata[c_spsr_rfempty_bit]) w_next = ST_RD_DR;
                    else if (w_poll_inc == c_poll_limit) w_next = ST_ERR;
                end
            end
            ST_RD_DR: begin
                w_access = 1'b1;
                w_adr    = c_adr_spdr;
                if (w_done) w_next = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready_i) w_next = ST_IDLE;
            end
            ST_ERR: begin
                w_access = 1'b1;
                w_we     = 1'b1;
                if (w_done) w_next = ST_ERR_RESP;
            end
            ST_ERR_RESP: begin
                if (rsp_ready_i) w_next = ST_CFG_SPCR;
            end
            default: w_next = ST_CFG_SPCR;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= ST_CFG_SPCR;
            r_data     <= 8'h00;
            r_last     <= 1'b0;
            r_poll_cnt <= 8'h00;
            r_rsp_data <= 8'h00;
            r_ss_n     <= 1'b1;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: if (cmd_valid_i) begin
                    r_data     <= cmd_data_i;
                    r_last     <= cmd_last_i;
                    r_ss_n     <= 1'b0;
                    r_poll_cnt <= 8'h00;
                end
                ST_POLL:  if (w_done && w_rdata[c_spsr_rfempty_bit]) r_poll_cnt <= w_poll_inc;
                ST_RD_DR: if (w_done) r_rsp_data <= w_rdata;
                ST_RESP:  if (rsp_ready_i && r_last) r_ss_n <= 1'b1;
                ST_ERR: if (w_done) begin
                    r_rsp_data <= 8'h00;
                    r_ss_n     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready_o = (r_state == ST_IDLE);
    assign busy_o      = (r_state != ST_IDLE);
    assign rsp_valid_o = (r_state == ST_RESP) || (r_state == ST_ERR_RESP);
    assign rsp_err_o   = (r_state == ST_ERR_RESP);
    assign rsp_data_o  = r_rsp_data;
    assign ss_n_o      = r_ss_n;

    spi_wb_access u_wb_access (
        .clk      (clk_i),
        .rst_n    (rst_i),
        .i_start  (w_start),
        .i_we     (w_we),
        .i_adr    (w_adr),
        .i_wdata  (w_wdata),
        .o_busy   (w_wb_busy),
        .o_done   (w_done),
        .o_rdata  (w_rdata),
        .o_wb_cyc (wb_cyc_o),
        .o_wb_stb (wb_stb_o),
        .o_wb_we  (wb_we_o),
        .o_wb_adr (wb_adr_o),
        .o_wb_dat (wb_dat_o),
        .i_wb_dat (wb_dat_i),
        .i_wb_ack (wb_ack_i)
    );

endmodule

`default_nettype wire

// File: tb/tb_spi_xfer_sequencer.sv
// ============================================================================
// Module   : tb_spi_xfer_sequencer
// Contents : Self-checking bench with a loopback simple_spi_top register model
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_xfer_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_last = 1'b0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       ss_n;
    logic       busy;
    logic       wb_cyc, wb_stb, wb_we, wb_ack;
    logic [7:0] wb_adr, wb_dat_w, wb_dat_r;

    always #5 clk = ~clk;

    spi_xfer_sequencer #(
        .SPR(2'b00), .ESPR(2'b00), .CPOL(1'b0), .CPHA(1'b0), .POLL_LIMIT(4)
    ) dut (
        .clk_i(clk), .rst_i(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_data_i(cmd_data), .cmd_last_i(cmd_last),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
        .ss_n_o(ss_n), .busy_o(busy),
        .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we),
        .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_w),
        .wb_dat_i(wb_dat_r), .wb_ack_i(wb_ack)
    );

    // ---------------- SPI core model: 1-cycle ack, MOSI looped to MISO ----
    bit          stuck = 1'b0;
    int          empty_reads = 0;
    int          spsr_cnt = 0;
    logic        rx_full = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic [7:0]  spcr = 8'h00;
    logic [7:0]  sper = 8'h00;
    logic [7:0]  spsr_val;
    logic [16:0] log_mem [0:255];
    int          log_n = 0;
    int          log_rd = 0;
    int          ss_hi_cnt = 0;

    assign wb_ack   = wb_cyc & wb_stb;
    assign spsr_val = (stuck || (spsr_cnt < empty_reads) || !rx_full) ? 8'h05 : 8'h04;
    assign wb_dat_r = (wb_adr == 8'h01) ? spsr_val :
                      (wb_adr == 8'h02) ? rx_byte  :
                      (wb_adr == 8'h00) ? spcr     : sper;

    always @(posedge clk) begin
        if (wb_cyc && wb_stb) begin
            if (log_n < 256) log_mem[log_n] <= {wb_we, wb_adr, wb_dat_w};
            log_n <= log_n + 1;
            if (wb_we) begin
                case (wb_adr)
                    8'h00: begin spcr <= wb_dat_w; if (wb_dat_w == 8'h00) rx_full <= 1'b0; end
                    8'h02: begin rx_byte <= wb_dat_w; rx_full <= !stuck; spsr_cnt <= 0; end
                    8'h03: sper <= wb_dat_w;
                    default: ;
                endcase
            end else if (wb_adr == 8'h01) begin
                spsr_cnt <= spsr_cnt + 1;
            end else if (wb_adr == 8'h02) begin
                rx_full <= 1'b0;
            end
        end
    end

    always @(negedge clk) if (ss_n) ss_hi_cnt <= ss_hi_cnt + 1;

    // ---------------- scoreboard and stimulus helpers ---------------------
    int         n_tests = 0;
    int         n_fail = 0;
    logic [8:0] exp_q [$];

    function automatic logic [16:0] log_pop();
        logic [16:0] e;
        e = 17'h1FFFF;
        if (log_rd < log_n && log_rd < 256) e = log_mem[log_rd];
        log_rd++;
        return e;
    endfunction

    task automatic send_cmd(input logic [7:0] d, input logic last, output bit ok);
        ok = 1'b0;
        cmd_valid = 1'b1; cmd_data = d; cmd_last = last;
        for (int i = 0; i < 100; i++) begin
            if (cmd_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input bit ack, output logic [7:0] d, output logic e,
                            output bit ok, output int cyc);
        ok = 1'b0; d = 8'h00; e = 1'b0; cyc = 1;
        for (int i = 0; i < 400; i++) begin
            if (rsp_valid) begin ok = 1'b1; d = rsp_data; e = rsp_err; break; end
            @(negedge clk);
            cyc++;
        end
        if (ok && ack) begin
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
        end
    endtask

    // ---------------- scenarios ---------------------------------------------
    task automatic test_reset();
        logic [16:0] e;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({cmd_ready, rsp_valid, rsp_err, ss_n, busy} !== 5'b00011) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 00011", {cmd_ready, rsp_valid, rsp_err, ss_n, busy});
        end
        n_tests++;
        if ({wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_w, rsp_data} !== 27'h0) begin
            n_fail++; $display("FAIL reset_wb: got %h expected 0", {wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_w, rsp_data});
        end
        log_rd = log_n;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_tests++;
        if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL ready_early: got %b expected 0", cmd_ready); end
        @(negedge clk);
        n_tests++;
        if ({cmd_ready, ss_n} !== 2'b11) begin n_fail++; $display("FAIL ready_cycle6: got %b expected 11", {cmd_ready, ss_n}); end
        e = log_pop();
        n_tests++;
        if (e !== {1'b1, 8'h00, 8'h50}) begin n_fail++; $display("FAIL cfg_spcr: got %h expected %h", e, {1'b1, 8'h00, 8'h50}); end
        e = log_pop();
        n_tests++;
        if (e !== {1'b1, 8'h03, 8'h00}) begin n_fail++; $display("FAIL cfg_sper: got %h expected %h", e, {1'b1, 8'h03, 8'h00}); end
    endtask

    task automatic test_single();
        bit ok, rok; logic [7:0] d; logic er; int cyc; logic [8:0] exp; logic [16:0] e;
        logic [16:0] exp_log [3];
        exp_log[0] = {1'b1, 8'h02, 8'hA5};
        exp_log[1] = {1'b0, 8'h01, 8'h00};
        exp_log[2] = {1'b0, 8'h02, 8'h00};
        log_rd = log_n;
        exp_q.push_back({1'b0, 8'hA5});
        send_cmd(8'hA5, 1'b1, ok);
        n_tests++;
        if ({ok, ss_n, cmd_ready} !== 3'b100) begin n_fail++; $display("FAIL single_accept: got %b expected 100", {ok, ss_n, cmd_ready}); end
        wait_rsp(1'b1, d, er, rok, cyc);
        exp = exp_q.pop_front();
        n_tests++;
        if ({rok, er, d} !== {1'b1, exp}) begin n_fail++; $display("FAIL single_rsp: got %h expected %h", {rok, er, d}, {1'b1, exp}); end
        n_tests++;
        if (cyc !== 10) begin n_fail++; $display("FAIL single_latency: got %0d expected 10", cyc); end
        n_tests++;
        if ({ss_n, cmd_ready} !== 2'b11) begin n_fail++; $display("FAIL single_ss_release: got %b expected 11", {ss_n, cmd_ready}); end
        for (int i = 0; i < 3; i++) begin
            e = log_pop();
            n_tests++;
            if (e !== exp_log[i]) begin n_fail++; $display("FAIL single_wb[%0d]: got %h expected %h", i, e, exp_log[i]); end
        end
    endtask

    task automatic test_burst();
        bit ok, rok; logic [7:0] d; logic er; int cyc; logic [8:0] exp; int hi0;
        logic [7:0] bytes [3];
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
        hi0 = 0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({1'b0, bytes[i]});
            send_cmd(bytes[i], (i == 2), ok);
            if (i == 0) hi0 = ss_hi_cnt;
            wait_rsp(1'b0, d, er, rok, cyc);
            if (i == 2) begin
                n_tests++;
                if (ss_hi_cnt !== hi0) begin n_fail++; $display("FAIL burst_ss_low: high samples %0d expected 0", ss_hi_cnt - hi0); end
            end
            if (rok) begin rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0; end
            exp = exp_q.pop_front();
            n_tests++;
            if ({ok, rok, er, d} !== {2'b11, exp}) begin n_fail++; $display("FAIL burst_rsp[%0d]: got %h expected %h", i, {ok, rok, er, d}, {2'b11, exp}); end
        end
        n_tests++;
        if (ss_n !== 1'b1) begin n_fail++; $display("FAIL burst_ss_release: got %b expected 1", ss_n); end
    endtask

    task automatic test_poll_boundary();
        bit ok, rok; logic [7:0] d; logic er; int cyc; logic [8:0] exp; int reads;
        logic [16:0] e;
        empty_reads = 3;
        log_rd = log_n;
        exp_q.push_back({1'b0, 8'hC3});
        send_cmd(8'hC3, 1'b1, ok);
        wait_rsp(1'b1, d, er, rok, cyc);
        exp = exp_q.pop_front();
        n_tests++;
        if ({ok, rok, er, d} !== {2'b11, exp}) begin n_fail++; $display("FAIL limit_success: got %h expected %h", {ok, rok, er, d}, {2'b11, exp}); end
        n_tests++;
        if (cyc !== 19) begin n_fail++; $display("FAIL limit_latency: got %0d expected 19", cyc); end
        reads = 0;
        while (log_rd < log_n) begin
            e = log_pop();
            if (e[16:8] == {1'b0, 8'h01}) reads++;
        end
        n_tests++;
        if (reads !== 4) begin n_fail++; $display("FAIL limit_spsr_reads: got %0d expected 4", reads); end
        empty_reads = 0;
    endtask

    task automatic test_timeout();
        bit ok, rok; logic [7:0] d; logic er; int cyc; logic [8:0] exp; logic [16:0] e;
        logic [16:0] exp_log [6];
        exp_log[0] = {1'b1, 8'h02, 8'h3C};
        exp_log[1] = {1'b0, 8'h01, 8'h00};
        exp_log[2] = {1'b0, 8'h01, 8'h00};
        exp_log[3] = {1'b0, 8'h01, 8'h00};
        exp_log[4] = {1'b0, 8'h01, 8'h00};
        exp_log[5] = {1'b1, 8'h00, 8'h00};
        stuck = 1'b1;
        log_rd = log_n;
        exp_q.push_back({1'b1, 8'h00});
        send_cmd(8'h3C, 1'b1, ok);
        wait_rsp(1'b0, d, er, rok, cyc);
        n_tests++;
        if (ss_n !== 1'b1) begin n_fail++; $display("FAIL timeout_ss: got %b expected 1", ss_n); end
        exp = exp_q.pop_front();
        n_tests++;
        if ({ok, rok, er, d} !== {2'b11, exp}) begin n_fail++; $display("FAIL timeout_rsp: got %h expected %h", {ok, rok, er, d}, {2'b11, exp}); end
        for (int i = 0; i < 6; i++) begin
            e = log_pop();
            n_tests++;
            if (e !== exp_log[i]) begin n_fail++; $display("FAIL timeout_wb[%0d]: got %h expected %h", i, e, exp_log[i]); end
        end
        stuck = 1'b0;
        rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
        for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
        n_tests++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL timeout_recfg_ready: got %b expected 1", cmd_ready); end
        e = log_pop();
        n_tests++;
        if (e !== {1'b1, 8'h00, 8'h50}) begin n_fail++; $display("FAIL timeout_recfg_spcr: got %h expected %h", e, {1'b1, 8'h00, 8'h50}); end
        e = log_pop();
        n_tests++;
        if (e !== {1'b1, 8'h03, 8'h00}) begin n_fail++; $display("FAIL timeout_recfg_sper: got %h expected %h", e, {1'b1, 8'h03, 8'h00}); end
    endtask

    task automatic test_backpressure();
        bit ok, rok; logic [7:0] d; logic er; int cyc; logic [8:0] exp; int bad;
        exp_q.push_back({1'b0, 8'h5A});
        send_cmd(8'h5A, 1'b1, ok);
        wait_rsp(1'b0, d, er, rok, cyc);
        exp = exp_q.pop_front();
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_tests++;
            if ({rsp_valid, rsp_err, rsp_data, wb_cyc, cmd_ready} !== {1'b1, exp, 2'b00}) begin
                n_fail++;
                $display("FAIL backpressure[%0d]: got %h expected %h", i,
                         {rsp_valid, rsp_err, rsp_data, wb_cyc, cmd_ready}, {1'b1, exp, 2'b00});
            end
        end
        rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
        n_tests++;
        if ({rok, cmd_ready, rsp_valid} !== 3'b110) begin n_fail++; $display("FAIL backpressure_release: got %b expected 110", {rok, cmd_ready, rsp_valid}); end
    endtask

    task automatic test_reset_mid();
        bit ok, seen; logic [16:0] e;
        stuck = 1'b1;
        send_cmd(8'h99, 1'b1, ok);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (wb_cyc && wb_adr == 8'h01) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        n_tests++;
        if (seen !== 1'b1) begin n_fail++; $display("FAIL mid_poll_seen: got %b expected 1", seen); end
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_w} !== 19'h0) begin n_fail++; $display("FAIL mid_reset_wb: got %h expected 0", {wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_w}); end
        n_tests++;
        if ({cmd_ready, rsp_valid, rsp_err, ss_n, busy, rsp_data} !== {5'b00011, 8'h00}) begin
            n_fail++; $display("FAIL mid_reset_ctrl: got %h expected %h", {cmd_ready, rsp_valid, rsp_err, ss_n, busy, rsp_data}, {5'b00011, 8'h00});
        end
        @(negedge clk);
        stuck = 1'b0;
        log_rd = log_n;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        n_tests++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL mid_recfg_ready: got %b expected 1", cmd_ready); end
        e = log_pop();
        n_tests++;
        if (e !== {1'b1, 8'h00, 8'h50}) begin n_fail++; $display("FAIL mid_recfg_spcr: got %h expected %h", e, {1'b1, 8'h00, 8'h50}); end
        e = log_pop();
        n_tests++;
        if (e !== {1'b1, 8'h03, 8'h00}) begin n_fail++; $display("FAIL mid_recfg_sper: got %h expected %h", e, {1'b1, 8'h03, 8'h00}); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_poll_boundary();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
